// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access sequencer: FSM states,
// response codes, memory strobe encodings and the ROM/RAM address map.
package mem_access_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ROM_LAST  = ADDR_W'(63);
    localparam logic [ADDR_W-1:0] RAM_FIRST = ADDR_W'(64);
    localparam logic [ADDR_W-1:0] MEM_LAST  = ADDR_W'(127);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK     = 2'b00,
        ERR_RANGE  = 2'b01,
        ERR_ROM_WR = 2'b10,
        ERR_MEM    = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        RWZ_READ  = 2'b00,
        RWZ_WRITE = 2'b01,
        RWZ_IDLE  = 2'b10
    } rwz_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    // Requests rejected before any memory cycle; range takes precedence over ROM write.
    function automatic err_e check_req(input req_t r);
        if (r.addr > MEM_LAST)                return ERR_RANGE;
        if (r.write && (r.addr < RAM_FIRST))  return ERR_ROM_WR;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Request/response and memory-side signals of the access sequencer.
interface mem_access_sequencer_if;
    import mem_access_pkg::*;

    logic              Req_Valid;
    logic              Req_Write;
    logic [ADDR_W-1:0] Req_Address;
    logic [DATA_W-1:0] Req_Data;
    logic              Req_Ready;
    logic              Rsp_Valid;
    logic [DATA_W-1:0] Rsp_Data;
    logic [1:0]        Rsp_Err_Code;
    logic [ADDR_W-1:0] MEM_Address;
    logic [DATA_W-1:0] MEM_Data_In;
    logic [1:0]        MEM_r_w_z_z;
    logic [DATA_W-1:0] MEM_Data_Out;
    logic              MEM_MFC;
    logic              MEM_ERROR;

    modport slave (
        input  Req_Valid, Req_Write, Req_Address, Req_Data,
        input  MEM_Data_Out, MEM_MFC, MEM_ERROR,
        output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err_Code,
        output MEM_Address, MEM_Data_In, MEM_r_w_z_z
    );

    modport master (
        output Req_Valid, Req_Write, Req_Address, Req_Data,
        output MEM_Data_Out, MEM_MFC, MEM_ERROR,
        input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err_Code,
        input  MEM_Address, MEM_Data_In, MEM_r_w_z_z
    );

endinterface

// File: rtl/mem_wait_counter.sv
// Saturating ACCESS-cycle counter with minimum-wait and timeout flags.
module mem_wait_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned MIN_WAIT       = 1
) (
    input  logic Clock,
    input  logic Reset_L,
    input  logic i_clear,
    input  logic i_en,
    output logic o_min_wait_c,
    output logic o_timeout_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_W'(TIMEOUT_CYCLES))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_min_wait_c = (r_count >= CNT_W'(MIN_WAIT));
    // High in the ACCESS cycle whose increment brings the count to the limit.
    assign o_timeout_c  = (r_count >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences single read/write requests onto a memory interface with
// address-map checks, minimum wait, timeout and a one-cycle response strobe.
module mem_access_sequencer
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned MIN_WAIT       = 1
) (
    input  logic                   Clock,
    input  logic                   Reset_L,
    mem_access_sequencer_if.slave  bus
);

    state_e            r_state, w_state_nxt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data,  w_rsp_data_nxt;
    logic [1:0]        r_rsp_err,   w_rsp_err_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_data,  w_mem_data_nxt;
    logic [1:0]        r_mem_rwz,   w_mem_rwz_nxt;
    logic              w_cnt_clear, w_cnt_en;
    logic              w_min_wait,  w_timeout;
    req_t              w_req;
    err_e              w_chk;

    mem_wait_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MIN_WAIT       (MIN_WAIT)
    ) u_wait_counter (
        .Clock        (Clock),
        .Reset_L      (Reset_L),
        .i_clear      (w_cnt_clear),
        .i_en         (w_cnt_en),
        .o_min_wait_c (w_min_wait),
        .o_timeout_c  (w_timeout)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        w_state_nxt    = r_state;
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_err_nxt  = r_rsp_err;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        w_mem_rwz_nxt  = RWZ_IDLE;
        w_cnt_clear    = 1'b0;
        w_cnt_en       = 1'b0;
        w_req          = '{write: bus.Req_Write, addr: bus.Req_Address, data: bus.Req_Data};
        w_chk          = check_req(w_req);

        unique case (r_state)
            ST_IDLE: begin
                if (bus.Req_Valid && r_req_ready) begin
                    if (w_chk != ERR_OK) begin
                        w_state_nxt    = ST_DONE;
                        w_rsp_err_nxt  = w_chk;
                        w_rsp_data_nxt = '0;
                    end else begin
                        w_state_nxt    = ST_ACCESS;
                        w_cnt_clear    = 1'b1;
                        w_mem_addr_nxt = w_req.addr;
                        w_mem_data_nxt = w_req.write ? w_req.data : '0;
                        w_mem_rwz_nxt  = w_req.write ? RWZ_WRITE : RWZ_READ;
                    end
                end
            end
            ST_ACCESS: begin
                w_cnt_en      = 1'b1;
                w_mem_rwz_nxt = r_mem_rwz;
                // Memory error outranks completion, completion outranks timeout.
                if (bus.MEM_ERROR) begin
                    w_state_nxt    = ST_DONE;
                    w_rsp_err_nxt  = ERR_MEM;
                    w_rsp_data_nxt = '0;
                    w_mem_rwz_nxt  = RWZ_IDLE;
                end else if (w_min_wait && bus.MEM_MFC) begin
                    w_state_nxt    = ST_DONE;
                    w_rsp_err_nxt  = ERR_OK;
                    w_rsp_data_nxt = (r_mem_rwz == RWZ_WRITE) ? '0 : bus.MEM_Data_Out;
                    w_mem_rwz_nxt  = RWZ_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt    = ST_DONE;
                    w_rsp_err_nxt  = ERR_MEM;
                    w_rsp_data_nxt = '0;
                    w_mem_rwz_nxt  = RWZ_IDLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= ERR_OK;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_rwz   <= RWZ_IDLE;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_DONE);
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
            r_mem_rwz   <= w_mem_rwz_nxt;
        end
    end

    assign bus.Req_Ready    = r_req_ready;
    assign bus.Rsp_Valid    = r_rsp_valid;
    assign bus.Rsp_Data     = r_rsp_data;
    assign bus.Rsp_Err_Code = r_rsp_err;
    assign bus.MEM_Address  = r_mem_addr;
    assign bus.MEM_Data_In  = r_mem_data;
    assign bus.MEM_r_w_z_z  = r_mem_rwz;

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, max ACCESS cycles before timeout abort.
REQ-002 Parameter MIN_WAIT, default 1, ACCESS cycles before MEM_MFC is honoured (covers synchronous ROM read latency).
REQ-003 Clock  in  1  single clock; all state on rising edge.
REQ-004 Reset_L  in  1  asynchronous, active-low reset.
REQ-005 Req_Valid  in  1  control unit requests an access.
REQ-006 Req_Write  in  1  1 = write, 0 = read.
REQ-007 Req_Address  in  32  word address.
REQ-008 Req_Data  in  32  write data.
REQ-009 Req_Ready  out  1  sequencer accepts a request this cycle.
REQ-010 Rsp_Valid  out  1  one-cycle completion strobe.
REQ-011 Rsp_Data  out  32  read data.
REQ-012 Rsp_Err_Code  out  2  00 ok, 01 range, 10 ROM write, 11 timeout/memory error.
REQ-013 MEM_Address  out  32  word address to memory interface.
REQ-014 MEM_Data_In  out  32  write data to memory interface.
REQ-015 MEM_r_w_z_z  out  2  00 read, 01 write, 10 idle/high-Z.
REQ-016 MEM_Data_Out  in  32  read data from memory interface.
REQ-017 MEM_MFC  in  1  memory function complete.
REQ-018 MEM_ERROR  in  1  memory reports unmapped address.

Function
REQ-019 States IDLE, ACCESS, DONE; all outputs registered.
REQ-020 IDLE: Req_Ready=1, MEM_r_w_z_z=10; on Req_Valid, capture address, data and write flag.
REQ-021 On capture: address>127 -> DONE, code 01; write with address<64 (ROM) -> DONE, code 10; neither issues a memory cycle.
REQ-022 Otherwise -> ACCESS; wait counter cleared to 0.
REQ-023 ACCESS: MEM_Address, MEM_Data_In, MEM_r_w_z_z (00/01) held stable for every ACCESS cycle; Req_Ready=0.
REQ-024 ACCESS: counter increments each cycle, saturating at TIMEOUT_CYCLES.
REQ-025 ACCESS: MEM_ERROR=1 -> DONE, code 11 (priority over MFC).
REQ-026 ACCESS: counter>=MIN_WAIT and MEM_MFC=1 -> DONE, code 00; read latches MEM_Data_Out into Rsp_Data on that edge.
REQ-027 ACCESS: counter=TIMEOUT_CYCLES without completion -> DONE, code 11.
REQ-028 DONE: Rsp_Valid=1 exactly one cycle, MEM_r_w_z_z=10, Req_Ready=0; next state IDLE.
REQ-029 Rsp_Data=0 for writes and any nonzero code.
REQ-030 Nominal timing (MIN_WAIT=1, MFC=1): accept edge ends cycle N, ACCESS N+1..N+2, Rsp_Valid N+3, Req_Ready N+4; 4-cycle request-to-request.
REQ-031 Req_Valid outside IDLE ignored; no queuing.

Reset
REQ-032 Reset_L=0 at any time, including mid-ACCESS: state IDLE, MEM_r_w_z_z=10, Req_Ready=0 while asserted, Rsp_Valid=0, Rsp_Err_Code=00, Rsp_Data=0, MEM_Address=0, MEM_Data_In=0, counter=0.
REQ-033 First request accepted no earlier than first rising edge after deassertion; aborted access yields no Rsp_Valid.

Structure
REQ-034 Shared package mem_access_pkg: state encoding, error codes, MEM_r_w_z_z encodings, ROM_LAST=63, RAM_FIRST=64, MEM_LAST=127.
REQ-035 One sub-module mem_wait_counter: clear, enable, saturating count, MIN_WAIT-reached and timeout flags.

Verification
REQ-036 Read 0x05, MFC=1, ROM returns 0xDEADBEEF -> Rsp_Valid at N+3, Rsp_Data=0xDEADBEEF, code 00, MEM_r_w_z_z=00 for 2 cycles.
REQ-037 Write 0x12345678 to 0x45 -> MEM_r_w_z_z=01, MEM_Data_In=0x12345678 stable 2 cycles, code 00, Rsp_Data=0.
REQ-038 Write 0x10 -> no memory cycle (MEM_r_w_z_z stays 10), Rsp_Valid at N+1, code 10; read 0x80 -> code 01.
REQ-039 Read 0x50, MFC held 0 -> code 11 after 15 ACCESS cycles, exactly one Rsp_Valid pulse.
REQ-040 Reset_L pulsed low in second ACCESS cycle -> immediate IDLE, MEM_r_w_z_z=10, no Rsp_Valid; next request completes normally.
